// File: rtl/rotary_encoder_event_arbiter.sv
// rotary_encoder_event_arbiter
//   Gathers step pulses from several rotary encoder cores into per-channel
//   saturating signed accumulators and drains them, one channel at a time,
//   round-robin onto a single valid/ready event stream.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enc_valid_change[N] one-cycle step pulse per channel
//   enc_direction[N]    1 = +1 step, 0 = -1 step (valid with the pulse)
//   evt_valid/evt_ready event handshake
//   evt_id              channel of the presented event
//   evt_delta           signed net step count of the event (never 0 while valid)
//   clear_overflow[N]   per-channel clear of the sticky overflow flag
//   overflow[N]         sticky saturation flag per channel

// Per-channel accumulator with saturation and sticky overflow.
module rotary_encoder_event_arbiter_ch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_pulse,
  input  logic         i_dir,
  input  logic         i_grant,
  input  logic         i_clr_ovf,
  output logic [W-1:0] o_acc,
  output logic         o_ovf
);
  localparam logic [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_acc;
  logic [W-1:0] w_acc_nxt;
  logic         r_ovf;
  logic         w_sat;

  // A grant empties the accumulator; a pulse in the same cycle then starts
  // from zero, so it can never saturate and is never lost.
  always_comb begin
    w_sat     = 1'b0;
    w_acc_nxt = i_grant ? '0 : r_acc;
    if (i_pulse) begin
      if (!i_grant && i_dir && (r_acc == ACC_MAX))
        w_sat = 1'b1;
      else if (!i_grant && !i_dir && (r_acc == ACC_MIN))
        w_sat = 1'b1;
      else
        w_acc_nxt = i_dir ? (w_acc_nxt + ONE) : (w_acc_nxt - ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      // set beats clear
      if (w_sat)          r_ovf <= 1'b1;
      else if (i_clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;
endmodule

module rotary_encoder_event_arbiter #(
  parameter  int NR_OF_ENCODERS_P = 4,
  parameter  int DELTA_WIDTH_P    = 8,
  localparam int ID_WIDTH_P       = $clog2(NR_OF_ENCODERS_P)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NR_OF_ENCODERS_P-1:0] enc_valid_change,
  input  logic [NR_OF_ENCODERS_P-1:0] enc_direction,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [ID_WIDTH_P-1:0]       evt_id,
  output logic [DELTA_WIDTH_P-1:0]    evt_delta,
  input  logic [NR_OF_ENCODERS_P-1:0] clear_overflow,
  output logic [NR_OF_ENCODERS_P-1:0] overflow
);
  localparam int N  = NR_OF_ENCODERS_P;
  localparam int W  = DELTA_WIDTH_P;
  localparam int IW = ID_WIDTH_P;

  typedef enum logic {IDLE_E, PRESENT_E} state_t;

  state_t                r_state, w_state_nxt;
  logic [N-1:0][W-1:0]   w_acc;
  logic [N-1:0]          w_cand;
  logic [N-1:0]          w_grant;
  logic [IW-1:0]         r_rr_ptr;
  logic [IW-1:0]         w_gnt_id;
  logic [IW:0]           w_sum;
  logic [IW:0]           w_rr_sum;
  logic                  w_found;
  logic                  w_grant_en;
  logic                  w_evt_valid;
  logic [IW-1:0]         r_evt_id;
  logic [W-1:0]          r_evt_delta;

  for (genvar i = 0; i < N; i++) begin : g_ch
    rotary_encoder_event_arbiter_ch #(.W(W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_pulse   (enc_valid_change[i]),
      .i_dir     (enc_direction[i]),
      .i_grant   (w_grant[i]),
      .i_clr_ovf (clear_overflow[i]),
      .o_acc     (w_acc[i]),
      .o_ovf     (overflow[i])
    );
    assign w_cand[i]  = |w_acc[i];
    assign w_grant[i] = w_grant_en && (w_gnt_id == IW'(i));
  end

  // Round-robin: first nonzero accumulator at or after r_rr_ptr, wrapping.
  // rr_ptr + k < 2N, so one conditional subtract is enough for the modulo.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_sum    = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      if (!w_found && w_cand[w_sum[IW-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_rr_sum = {1'b0, w_gnt_id} + (IW+1)'(1);
    if (w_rr_sum >= (IW+1)'(N)) w_rr_sum = '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_evt_valid = 1'b0;
    case (r_state)
      IDLE_E: begin
        if (w_found) begin
          w_grant_en  = 1'b1;
          w_state_nxt = PRESENT_E;
        end
      end
      PRESENT_E: begin
        w_evt_valid = 1'b1;
        // accept with another candidate ready: regrant without a bubble
        if (evt_ready) begin
          if (w_found) w_grant_en  = 1'b1;
          else         w_state_nxt = IDLE_E;
        end
      end
      default: begin
        w_state_nxt = IDLE_E;
        w_evt_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE_E;
      r_rr_ptr    <= '0;
      r_evt_id    <= '0;
      r_evt_delta <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_en) begin
        r_evt_id    <= w_gnt_id;
        r_evt_delta <= w_acc[w_gnt_id];   // pre-pulse value on collision
        r_rr_ptr    <= w_rr_sum[IW-1:0];
      end
    end
  end

  assign evt_valid = w_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_delta = r_evt_delta;
endmodule

// File: tb/tb_rotary_encoder_event_arbiter.sv
module tb_rotary_encoder_event_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] enc_valid_change, enc_direction, clear_overflow, overflow;
  logic       evt_valid, evt_ready;
  logic [1:0] evt_id;
  logic [7:0] evt_delta;

  typedef struct {
    logic [1:0] id;
    logic [7:0] delta;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  rotary_encoder_event_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enc_valid_change (enc_valid_change),
    .enc_direction    (enc_direction),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .evt_id           (evt_id),
    .evt_delta        (evt_delta),
    .clear_overflow   (clear_overflow),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.delta = d;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [3:0] m, input logic [3:0] dir);
    enc_valid_change = m;
    enc_direction    = dir;
    tick();
    enc_valid_change = '0;
    enc_direction    = '0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || evt_valid) && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_idle"}, {31'd0, evt_valid}, 0);
  endtask

  // Scoreboard: each handshake (sampled mid-cycle, completes on next edge)
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_evt", {22'd0, evt_id, evt_delta}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("evt_id", {30'd0, evt_id}, {30'd0, e.id});
        chk("evt_delta", {24'd0, evt_delta}, {24'd0, e.delta});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    enc_valid_change = '0;
    enc_direction = '0;
    clear_overflow = '0;
    evt_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, evt_valid}, 0);
    chk("rst_id", {30'd0, evt_id}, 0);
    chk("rst_delta", {24'd0, evt_delta}, 0);
    chk("rst_ovf", {28'd0, overflow}, 0);
    rst_n = 1'b1;
    tick();

    // 1: single right pulse on ch2, latency 2
    evt_ready = 1'b1;
    push(2, 8'd1);
    pulse(4'b0100, 4'b0100);
    chk("t1_valid_t1", {31'd0, evt_valid}, 0);
    tick();
    chk("t1_valid_t2", {31'd0, evt_valid}, 1);
    chk("t1_id", {30'd0, evt_id}, 2);
    chk("t1_delta", {24'd0, evt_delta}, 1);
    tick();
    chk("t1_valid_after", {31'd0, evt_valid}, 0);
    drain("t1");

    // 2: stall; ch3 blocker, ch0 +5/-2, ch3 -3; then back-to-back drain
    evt_ready = 1'b0;
    push(3, 8'd1);
    push(0, 8'd3);
    push(3, 8'hFD);
    pulse(4'b1000, 4'b1000);
    tick();
    for (int k = 0; k < 7; k++) begin
      pulse({(k < 3), 2'b00, 1'b1}, {3'b000, (k < 5)});
      chk("t2_stall_valid", {31'd0, evt_valid}, 1);
      chk("t2_stall_id", {30'd0, evt_id}, 3);
      chk("t2_stall_delta", {24'd0, evt_delta}, 1);
    end
    evt_ready = 1'b1;
    tick();
    chk("t2_b2b_v1", {31'd0, evt_valid}, 1);
    chk("t2_b2b_id1", {30'd0, evt_id}, 0);
    chk("t2_b2b_d1", {24'd0, evt_delta}, 3);
    tick();
    chk("t2_b2b_v2", {31'd0, evt_valid}, 1);
    chk("t2_b2b_id2", {30'd0, evt_id}, 3);
    chk("t2_b2b_d2", {24'd0, evt_delta}, 32'hFD);
    tick();
    chk("t2_end_valid", {31'd0, evt_valid}, 0);
    drain("t2");

    // 3: all pending with rr_ptr=1; new ch1 pulse during ch2 grant
    evt_ready = 1'b0;
    push(0, 8'd1);
    push(1, 8'd1);
    push(2, 8'd1);
    push(3, 8'd1);
    push(0, 8'd1);
    push(1, 8'd1);
    pulse(4'b0001, 4'b0001);
    tick();
    pulse(4'b1111, 4'b1111);
    evt_ready = 1'b1;
    tick();
    pulse(4'b0010, 4'b0010);
    drain("t3");

    // 4: saturation on ch1 and overflow handling
    evt_ready = 1'b0;
    push(1, 8'd1);
    push(1, 8'd127);
    for (int k = 0; k < 130; k++) pulse(4'b0010, 4'b0010);
    chk("t4_ovf_set", {28'd0, overflow}, 32'h2);
    chk("t4_stall_delta", {24'd0, evt_delta}, 1);
    tick();
    tick();
    chk("t4_ovf_sticky", {28'd0, overflow}, 32'h2);
    clear_overflow = 4'b0010;
    tick();
    clear_overflow = '0;
    chk("t4_ovf_clr", {28'd0, overflow}, 0);
    clear_overflow = 4'b0010;
    pulse(4'b0010, 4'b0010);
    clear_overflow = '0;
    chk("t4_set_wins", {28'd0, overflow}, 32'h2);
    evt_ready = 1'b1;
    drain("t4");
    chk("t4_ovf_after_drain", {28'd0, overflow}, 32'h2);
    clear_overflow = 4'b0010;
    tick();
    clear_overflow = '0;
    chk("t4_ovf_clr2", {28'd0, overflow}, 0);

    // 5: pulse on ch0 in the cycle ch0 is granted with acc=+4
    evt_ready = 1'b0;
    push(2, 8'd1);
    push(0, 8'd4);
    push(0, 8'd1);
    pulse(4'b0100, 4'b0100);
    tick();
    for (int k = 0; k < 4; k++) pulse(4'b0001, 4'b0001);
    evt_ready = 1'b1;
    pulse(4'b0001, 4'b0001);
    chk("t5_coll_delta", {24'd0, evt_delta}, 4);
    drain("t5");

    // 6: reset while presenting with pending counts
    evt_ready = 1'b0;
    pulse(4'b1000, 4'b1000);
    tick();
    pulse(4'b0011, 4'b0011);
    chk("t6_pre_valid", {31'd0, evt_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, evt_valid}, 0);
    chk("t6_async_id", {30'd0, evt_id}, 0);
    chk("t6_async_delta", {24'd0, evt_delta}, 0);
    evt_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t6_no_evt", {31'd0, evt_valid}, 0);
    end
    push(1, 8'd1);
    pulse(4'b0010, 4'b0010);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
